// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the datapath it drives.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMMEXEC  = 4'd10,
    S_IMMWB    = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_FUNCT = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG       = 2'd0,
    SRCB_FOUR      = 2'd1,
    SRCB_IMM       = 2'd2,
    SRCB_IMM_SHIFT = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JUMP   = 2'd2
  } pc_source_e;

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter: increments on enable, wraps naturally, async clear.
module mc_retire_counter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (en) count <= count + Width'(1);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with memory handshake, stall, illegal-opcode trap and retire counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int OpcodeSize = 6,
  parameter int ALUOpSize  = 4,
  parameter int StateSize  = 4,
  parameter int CountWidth = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [OpcodeSize-1:0] Opcode,
  input  logic                  MemReady,
  input  logic                  Stall,
  output logic [StateSize-1:0]  SystemState,
  output logic                  MemReq,
  output logic [1:0]            PCSource,
  output logic                  PCWrite,
  output logic                  BEQcontrol,
  output logic                  BNEcontrol,
  output logic [ALUOpSize-1:0]  AluOp,
  output logic                  AluSrcA,
  output logic [1:0]            AluSrcB,
  output logic                  IRWrite,
  output logic                  RFWrite,
  output logic                  MDRWrite,
  output logic                  DMemWrite,
  output logic                  MemToReg,
  output logic                  ImmedAddr,
  output logic                  IllegalOp,
  output logic [CountWidth-1:0] RetireCount
);

  localparam logic [OpcodeSize-1:0] RTYPE = OpcodeSize'(OP_RTYPE);
  localparam logic [OpcodeSize-1:0] J     = OpcodeSize'(OP_J);
  localparam logic [OpcodeSize-1:0] BEQ   = OpcodeSize'(OP_BEQ);
  localparam logic [OpcodeSize-1:0] BNE   = OpcodeSize'(OP_BNE);
  localparam logic [OpcodeSize-1:0] ADDI  = OpcodeSize'(OP_ADDI);
  localparam logic [OpcodeSize-1:0] ANDI  = OpcodeSize'(OP_ANDI);
  localparam logic [OpcodeSize-1:0] ORI   = OpcodeSize'(OP_ORI);
  localparam logic [OpcodeSize-1:0] LW    = OpcodeSize'(OP_LW);
  localparam logic [OpcodeSize-1:0] SW    = OpcodeSize'(OP_SW);

  state_e     state, next_state;
  alu_op_e    alu_op;
  alu_src_b_e alu_src_b;
  pc_source_e pc_source;
  logic mem_req, pc_write, beq, bne, ir_write, rf_write, mdr_write, dmem_write;
  logic alu_src_a, mem_to_reg, immed_addr, illegal;
  logic retire_en;
  logic [CountWidth-1:0] count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    next_state = state;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    ir_write   = 1'b0;
    rf_write   = 1'b0;
    mdr_write  = 1'b0;
    dmem_write = 1'b0;
    mem_to_reg = 1'b0;
    immed_addr = 1'b0;
    illegal    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SHIFT;
        case (Opcode)
          RTYPE:          next_state = S_EXEC;
          LW, SW:         next_state = S_MEMADDR;
          BEQ, BNE:       next_state = S_BRANCH;
          J:              next_state = S_JUMP;
          ADDI, ANDI, ORI: next_state = S_IMMEXEC;
          default:        next_state = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        immed_addr = 1'b1;
        next_state = (Opcode == SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        if (MemReady) begin
          mdr_write  = 1'b1;
          next_state = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_write   = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        dmem_write = 1'b1;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = S_RWB;
      end
      S_RWB, S_IMMWB: begin
        rf_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_ALUOUT;
        beq        = (Opcode == BEQ);
        bne        = (Opcode == BNE);
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PC_JUMP;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (Opcode)
          ANDI:    alu_op = ALU_AND;
          ORI:     alu_op = ALU_OR;
          default: begin
            alu_op     = ALU_ADD;
            immed_addr = 1'b1;
          end
        endcase
        next_state = S_IMMWB;
      end
      default: begin
        // TRAP and the unused encodings park here until reset
        illegal    = 1'b1;
        next_state = S_TRAP;
      end
    endcase

    // A stall freezes the FSM and drops every enable; a same-cycle MemReady is not consumed
    if (Stall) begin
      next_state = state;
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      beq        = 1'b0;
      bne        = 1'b0;
      ir_write   = 1'b0;
      rf_write   = 1'b0;
      mdr_write  = 1'b0;
      dmem_write = 1'b0;
    end
  end

  assign retire_en = Reset && (state != S_FETCH) && (next_state == S_FETCH);

  mc_retire_counter #(.Width(CountWidth)) u_retire (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (retire_en),
    .count (count)
  );

  assign SystemState = Reset ? StateSize'(state) : '0;
  assign MemReq      = Reset & mem_req;
  assign PCSource    = Reset ? pc_source : PC_ALU;
  assign PCWrite     = Reset & pc_write;
  assign BEQcontrol  = Reset & beq;
  assign BNEcontrol  = Reset & bne;
  assign AluOp       = Reset ? ALUOpSize'(alu_op) : '0;
  assign AluSrcA     = Reset & alu_src_a;
  assign AluSrcB     = Reset ? alu_src_b : SRCB_REG;
  assign IRWrite     = Reset & ir_write;
  assign RFWrite     = Reset & rf_write;
  assign MDRWrite    = Reset & mdr_write;
  assign DMemWrite   = Reset & dmem_write;
  assign MemToReg    = Reset & mem_to_reg;
  assign ImmedAddr   = Reset & immed_addr;
  assign IllegalOp   = Reset & illegal;
  assign RetireCount = Reset ? count : '0;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: directed per-cycle vectors queued by stimulus, checked by a monitor.
module tb_mc_control;
  import mc_pkg::*;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset, MemReady, Stall;
  logic [5:0]    Opcode;
  logic [3:0]    SystemState, AluOp;
  logic [1:0]    PCSource, AluSrcB;
  logic          MemReq, PCWrite, BEQcontrol, BNEcontrol, AluSrcA;
  logic          IRWrite, RFWrite, MDRWrite, DMemWrite, MemToReg, ImmedAddr, IllegalOp;
  logic [CW-1:0] RetireCount;

  always #5 Clk = ~Clk;

  mc_control #(.OpcodeSize(6), .ALUOpSize(4), .StateSize(4), .CountWidth(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady), .Stall(Stall),
    .SystemState(SystemState), .MemReq(MemReq), .PCSource(PCSource), .PCWrite(PCWrite),
    .BEQcontrol(BEQcontrol), .BNEcontrol(BNEcontrol), .AluOp(AluOp), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .IRWrite(IRWrite), .RFWrite(RFWrite), .MDRWrite(MDRWrite),
    .DMemWrite(DMemWrite), .MemToReg(MemToReg), .ImmedAddr(ImmedAddr), .IllegalOp(IllegalOp),
    .RetireCount(RetireCount)
  );

  // Enable vector: {MemReq, IRWrite, PCWrite, MDRWrite, RFWrite, DMemWrite, BEQ, BNE, IllegalOp}
  localparam logic [8:0] E0    = 9'b000000000;
  localparam logic [8:0] E_FW  = 9'b100000000;
  localparam logic [8:0] E_FR  = 9'b111000000;
  localparam logic [8:0] E_MR  = 9'b100100000;
  localparam logic [8:0] E_RF  = 9'b000010000;
  localparam logic [8:0] E_MW  = 9'b100001000;
  localparam logic [8:0] E_BNE = 9'b000000010;
  localparam logic [8:0] E_PC  = 9'b001000000;
  localparam logic [8:0] E_ILL = 9'b000000001;

  // Mux vector: {PCSource[1:0], AluOp[3:0], AluSrcA, AluSrcB[1:0], ImmedAddr, MemToReg}
  localparam logic [10:0] M_FETCH   = 11'b00_0000_0_01_0_0;
  localparam logic [10:0] M_DECODE  = 11'b00_0000_0_11_0_0;
  localparam logic [10:0] M_EXEC    = 11'b00_0010_1_00_0_0;
  localparam logic [10:0] M_MEMADDR = 11'b00_0000_1_10_1_0;
  localparam logic [10:0] M_MEMWB   = 11'b00_0000_0_00_0_1;
  localparam logic [10:0] M_BRANCH  = 11'b01_0001_1_00_0_0;
  localparam logic [10:0] M_JUMP    = 11'b10_0000_0_00_0_0;
  localparam logic [10:0] M_ANDI    = 11'b00_0011_1_10_0_0;
  localparam logic [10:0] M_ZERO    = 11'b00_0000_0_00_0_0;

  typedef struct {
    string       name;
    int          st;
    logic [8:0]  en;
    int          cnt;
    bit          chk_mux;
    logic [10:0] mux;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  wire [8:0]  en_act  = {MemReq, IRWrite, PCWrite, MDRWrite, RFWrite, DMemWrite,
                         BEQcontrol, BNEcontrol, IllegalOp};
  wire [10:0] mux_act = {PCSource, AluOp, AluSrcA, AluSrcB, ImmedAddr, MemToReg};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during that cycle
  task automatic step(input bit rst, input logic [5:0] op, input bit rdy, input bit stl,
                      input int st, input logic [8:0] en, input int cnt,
                      input bit cm, input logic [10:0] mux, input string name);
    exp_t e;
    Reset = rst; Opcode = op; MemReady = rdy; Stall = stl;
    e = '{name, st, en, cnt, cm, mux};
    q.push_back(e);
    @(posedge Clk); #1;
  endtask

  task automatic jump_seq(input int cnt);
    step(1, OP_J, 1, 0, 0, E_FR, cnt, 0, M_ZERO, "wrap_fetch");
    step(1, OP_J, 1, 0, 1, E0,   cnt, 0, M_ZERO, "wrap_decode");
    step(1, OP_J, 1, 0, 9, E_PC, cnt, 1, M_JUMP, "wrap_jump");
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.name, "_state"}, 32'(SystemState), 32'(e.st));
        check({e.name, "_en"},    32'(en_act),      32'(e.en));
        check({e.name, "_cnt"},   32'(RetireCount), 32'(e.cnt));
        if (e.chk_mux) check({e.name, "_mux"}, 32'(mux_act), 32'(e.mux));
      end
    end
  end

  initial begin : stimulus
    Reset = 1'b0; Opcode = '0; MemReady = 1'b0; Stall = 1'b0;
    @(posedge Clk); #1;
    step(0, OP_RTYPE, 1, 0, 0, E0, 0, 1, M_ZERO, "reset_a");
    step(0, OP_RTYPE, 1, 0, 0, E0, 0, 1, M_ZERO, "reset_b");

    // R-type, zero wait
    step(1, OP_RTYPE, 1, 0, 0, E_FR, 0, 1, M_FETCH,  "r_fetch");
    step(1, OP_RTYPE, 1, 0, 1, E0,   0, 1, M_DECODE, "r_decode");
    step(1, OP_RTYPE, 1, 0, 6, E0,   0, 1, M_EXEC,   "r_exec");
    step(1, OP_RTYPE, 1, 0, 7, E_RF, 0, 1, M_ZERO,   "r_rwb");

    // LW with 2 fetch waits and 3 read waits: 10 cycles, one MDRWrite pulse
    step(1, OP_LW, 0, 0, 0, E_FW, 1, 0, M_ZERO,    "lw_fetch_w1");
    step(1, OP_LW, 0, 0, 0, E_FW, 1, 0, M_ZERO,    "lw_fetch_w2");
    step(1, OP_LW, 1, 0, 0, E_FR, 1, 0, M_ZERO,    "lw_fetch");
    step(1, OP_LW, 1, 0, 1, E0,   1, 0, M_ZERO,    "lw_decode");
    step(1, OP_LW, 1, 0, 2, E0,   1, 1, M_MEMADDR, "lw_memaddr");
    step(1, OP_LW, 0, 0, 3, E_FW, 1, 0, M_ZERO,    "lw_read_w1");
    step(1, OP_LW, 0, 0, 3, E_FW, 1, 0, M_ZERO,    "lw_read_w2");
    step(1, OP_LW, 0, 0, 3, E_FW, 1, 0, M_ZERO,    "lw_read_w3");
    step(1, OP_LW, 1, 0, 3, E_MR, 1, 0, M_ZERO,    "lw_read");
    step(1, OP_LW, 1, 0, 4, E_RF, 1, 1, M_MEMWB,   "lw_memwb");

    // BNE then JUMP
    step(1, OP_BNE, 1, 0, 0, E_FR,  2, 0, M_ZERO,   "bne_fetch");
    step(1, OP_BNE, 1, 0, 1, E0,    2, 0, M_ZERO,   "bne_decode");
    step(1, OP_BNE, 1, 0, 8, E_BNE, 2, 1, M_BRANCH, "bne_branch");
    step(1, OP_J,   1, 0, 0, E_FR,  3, 0, M_ZERO,   "j_fetch");
    step(1, OP_J,   1, 0, 1, E0,    3, 0, M_ZERO,   "j_decode");
    step(1, OP_J,   1, 0, 9, E_PC,  3, 1, M_JUMP,   "j_jump");

    // SW with a 4-cycle stall over a ready memory
    step(1, OP_SW, 1, 0, 0, E_FR, 4, 0, M_ZERO,    "sw_fetch");
    step(1, OP_SW, 1, 0, 1, E0,   4, 0, M_ZERO,    "sw_decode");
    step(1, OP_SW, 1, 0, 2, E0,   4, 1, M_MEMADDR, "sw_memaddr");
    for (int i = 0; i < 4; i++)
      step(1, OP_SW, 1, 1, 5, E0, 4, 1, M_ZERO, "sw_stall");
    step(1, OP_SW, 1, 0, 5, E_MW, 4, 0, M_ZERO,    "sw_write");

    // Stall beats MemReady in FETCH; then ANDI
    step(1, OP_ANDI, 1, 1, 0,  E0,   5, 1, M_FETCH, "andi_fetch_stall");
    step(1, OP_ANDI, 1, 0, 0,  E_FR, 5, 1, M_FETCH, "andi_fetch");
    step(1, OP_ANDI, 1, 0, 1,  E0,   5, 0, M_ZERO,  "andi_decode");
    step(1, OP_ANDI, 1, 0, 10, E0,   5, 1, M_ANDI,  "andi_immexec");
    step(1, OP_ANDI, 1, 0, 11, E_RF, 5, 1, M_ZERO,  "andi_immwb");

    // Illegal opcode traps and holds; counter frozen
    step(1, 6'b111111, 1, 0, 0, E_FR, 6, 0, M_ZERO, "trap_fetch");
    step(1, 6'b111111, 1, 0, 1, E0,   6, 0, M_ZERO, "trap_decode");
    for (int i = 0; i < 3; i++)
      step(1, 6'b111111, 1, 0, 12, E_ILL, 6, 1, M_ZERO, "trap_hold");

    // Reset clears trap and counter; reset mid-fetch drops MemReq at once
    step(0, OP_J, 1, 0, 0, E0,   0, 1, M_ZERO, "trap_reset");
    step(1, OP_J, 0, 0, 0, E_FW, 0, 0, M_ZERO, "post_reset_fetch");
    step(0, OP_J, 0, 0, 0, E0,   0, 1, M_ZERO, "reset_mid_fetch");

    // 15 jumps reach 2^CW-1, the 16th wraps to 0
    for (int i = 0; i < 16; i++) jump_seq(i);
    step(1, OP_J, 0, 0, 0, E_FW, 0, 0, M_ZERO, "wrap_zero");

    repeat (2) @(posedge Clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Parametrised multi-cycle MIPS control unit, the next generation of the `CPU_Control` block. It drives the `Datapath` write enables and mux selects from the fetched opcode, as the current controller does. It adds:
- a ready/valid memory handshake with arbitrary wait states;
- an external stall input;
- jump and immediate-ALU instruction classes;
- an illegal-opcode trap;
- a retired-instruction counter.

## Interface
Parameters:
- `OpcodeSize`, 6, opcode field width
- `ALUOpSize`, 4, ALU operation code width
- `StateSize`, 4, `SystemState` width
- `CountWidth`, 32, retired-instruction counter width

Ports:
- `Clk` in 1: single clock, rising edge
- `Reset` in 1: asynchronous, active-low (0 = reset)
- `Opcode` in OpcodeSize: IR[31:26] from datapath
- `MemReady` in 1: memory completes the current request this cycle
- `Stall` in 1: freeze controller this cycle
- `SystemState` out StateSize: current FSM state
- `MemReq` out 1: memory access request
- `PCSource` out 2: 0 = ALU result, 1 = ALUOut register, 2 = jump target
- `PCWrite` out 1: unconditional PC load
- `BEQcontrol` out 1: conditional PC load on zero
- `BNEcontrol` out 1: conditional PC load on non-zero
- `AluOp` out ALUOpSize: 0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR
- `AluSrcA` out 1: 0 = PC, 1 = register A
- `AluSrcB` out 2: 0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate
- `IRWrite`, `RFWrite`, `MDRWrite`, `DMemWrite`, `MemToReg` out 1 each: datapath enables and selects, same meaning as the current controller
- `ImmedAddr` out 1: 0 = zero-extend immediate, 1 = sign-extend immediate
- `IllegalOp` out 1: trap indicator
- `RetireCount` out CountWidth: instructions completed since reset

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMREAD, 4 MEMWB
  - 5 MEMWRITE, 6 EXEC, 7 RWB, 8 BRANCH, 9 JUMP
  - 10 IMMEXEC, 11 IMMWB, 12 TRAP
  - Encodings 13–15 are unreachable; treat them as TRAP.
- FETCH:
  - `MemReq`=1, `AluSrcA`=0, `AluSrcB`=1, `AluOp`=ADD, `PCSource`=0.
  - While `MemReady`=0: hold state, `IRWrite`=`PCWrite`=0.
  - When `MemReady`=1: `IRWrite`=1, `PCWrite`=1, then go to DECODE.
- DECODE:
  - `AluSrcA`=0, `AluSrcB`=3, `AluOp`=ADD (branch target).
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 / 101011 → MEMADDR
    - 000100 / 000101 → BRANCH
    - 000010 → JUMP
    - 001000 / 001100 / 001101 → IMMEXEC
    - any other opcode → TRAP
- MEMADDR: `AluSrcA`=1, `AluSrcB`=2, `ImmedAddr`=1, `AluOp`=ADD. Next state MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: `MemReq`=1; wait for `MemReady`; `MDRWrite`=1 in the ready cycle; then MEMWB.
- MEMWB: `RFWrite`=1, `MemToReg`=1; then FETCH.
- MEMWRITE: `MemReq`=1, `DMemWrite`=1 held until `MemReady`; then FETCH.
- EXEC: `AluSrcA`=1, `AluSrcB`=0, `AluOp`=FUNCT; then RWB.
- RWB: `RFWrite`=1, `MemToReg`=0; then FETCH.
- BRANCH:
  - `AluSrcA`=1, `AluSrcB`=0, `AluOp`=SUB, `PCSource`=1.
  - `BEQcontrol`=1 for opcode 000100, `BNEcontrol`=1 for opcode 000101.
  - Then FETCH.
- JUMP: `PCSource`=2, `PCWrite`=1; then FETCH.
- IMMEXEC:
  - `AluSrcA`=1, `AluSrcB`=2.
  - ADDI: `AluOp`=ADD, `ImmedAddr`=1.
  - ANDI: `AluOp`=AND, `ImmedAddr`=0.
  - ORI: `AluOp`=OR, `ImmedAddr`=0.
  - Then IMMWB.
- IMMWB: `RFWrite`=1, `MemToReg`=0; then FETCH.
- TRAP: `IllegalOp`=1, all enables 0, `MemReq`=0. Left only by reset.
- Unlisted outputs are 0 in every state.
- Stall:
  - The state register holds.
  - Every write enable is forced to 0: `PCWrite`, `BEQcontrol`, `BNEcontrol`, `IRWrite`, `RFWrite`, `MDRWrite`, `DMemWrite`.
  - `MemReq` is forced to 0, and a `MemReady` sampled in a stalled cycle is ignored.
  - Mux selects keep their state values.
- `RetireCount`:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, RWB, BRANCH, JUMP or IMMWB.
  - Wraps modulo 2^CountWidth.
  - Never increments in TRAP.

## Timing
- `Reset`=0 takes effect asynchronously:
  - state = FETCH, `RetireCount` = 0.
  - All outputs are combinationally gated to 0 while `Reset`=0.
- First `MemReq` appears in the first cycle after `Reset` rises.
- Outputs are combinational from state, `Opcode`, `Stall` and `MemReady`.
- `IRWrite`, `PCWrite` in FETCH and `MDRWrite` in MEMREAD depend on same-cycle `MemReady` (Mealy).
- Zero-wait latency in cycles (first FETCH to return to FETCH):
  - R-type 4, ADDI/ANDI/ORI 4, LW 5, SW 4, branch 3, jump 3.
  - Each memory wait cycle adds 1.
  - Each stall cycle adds 1.
- `Stall`=1 together with `MemReady`=1: the stall wins and the memory access is not consumed.
- Reset mid-access: `MemReq` drops immediately; no enable pulses after reset asserts.

## Structure
- Package `mc_pkg` holds:
  - state enumeration;
  - opcode constants (RTYPE, J, BEQ, BNE, ADDI, ANDI, ORI, LW, SW);
  - AluOp, AluSrcB and PCSource encodings.
- The `Datapath` block imports the same package.
- One sub-module, `mc_retire_counter`: enable-driven counter with async active-low clear.
- The FSM and output decode stay in `mc_control`.

## Test plan
- Reset, then R-type (Opcode=0), `MemReady` tied 1 → states 0,1,6,7,0; `RFWrite` high only in state 7; `RetireCount`=1.
- LW with `MemReady` low for 2 cycles in FETCH and 3 cycles in MEMREAD → FETCH lasts 3 cycles; total 10 cycles; `MDRWrite` pulses exactly once.
- BNE (000101) → `BNEcontrol`=1 and `BEQcontrol`=0 in state 8, `PCSource`=1; JUMP → `PCWrite`=1 with `PCSource`=2 in state 9.
- `Stall`=1 for 4 cycles in MEMWRITE with `MemReady`=1 → state holds at 5, `DMemWrite`=`MemReq`=0; completes the cycle after `Stall` falls.
- Opcode 111111 → TRAP (12), `IllegalOp`=1 held; counter frozen; `Reset` low → state 0, count 0.
- Preload 2^CountWidth−1 retirements (CountWidth=4, 15 jumps), then one more → `RetireCount` wraps to 0.
